clock_display_scan: RTL and testbench
=====================================

Name: clock_display_scan

Overview:
- Time-multiplexed driver for the 4-digit common-anode 7-segment display.
- Consumes the six BCD digit outputs (hours, minutes, seconds) produced by the digital clock block.
- Shows HH.MM or MM.SS and flashes the field being adjusted.
- Runs on the fast board clock; the BCD inputs come from the slow clock domain, and the whole frame is snapshotted at once so a displayed frame never tears.

Parameters:
- CLK_HZ, 100_000_000, board clock frequency.
- REFRESH_HZ, 1000, per-digit scan rate. Cycles per digit = CLK_HZ/REFRESH_HZ, integer division, minimum 2.
- BLINK_HZ, 2, flash rate. Half-period = CLK_HZ/(2*BLINK_HZ) cycles, minimum 1.

Ports:
- clk_100mhz  in  1  board clock.
- disp_reset  in  1  asynchronous active-high reset.
- hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s  in  4 each  BCD digits.
- view_sel  in  1  0 = HH.MM, 1 = MM.SS.
- blink_field  in  2  00 none, 01 left pair, 10 right pair, 11 all four.
- an  out  4  digit anodes, active-low; an[0] is the rightmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Input sync: each BCD input and view_sel passes through a 2-flop synchroniser. blink_field is also 2-flop synchronised.
- Reset state:
  - an=4'hF, seg=7'h7F, dp=1.
  - Prescaler=0, digit_idx=0, blink counter=0, blink_phase=0, snapshot=all zero.
- Prescaler:
  - Counts 0..CLK_HZ/REFRESH_HZ-1.
  - scan_tick pulses on the terminal count.
  - On scan_tick, digit_idx (2 bits) increments and wraps 3→0.
- Snapshot: the synchronised digits and view are captured into the snapshot register on the scan_tick where digit_idx wraps 3→0. All four digits of a frame therefore come from one capture.
- Digit mapping:
  - view 0: idx3=hr_10s, idx2=hr_1s, idx1=min_10s, idx0=min_1s.
  - view 1: idx3=min_10s, idx2=min_1s, idx1=sec_10s, idx0=sec_1s.
- Decode:
  - 0-9 standard patterns.
  - Any value >9 shows '-' (seg=7'b0111111).
- Anti-ghost: the cycle immediately after scan_tick drives an=4'hF (blank cycle). From the following cycle, an drives the one-hot-low select for the new digit_idx. seg and dp update on the same cycle as an.
- Output latency: registered outputs. The new digit is visible 2 cycles after scan_tick.
- Blink:
  - blink_phase toggles at the end of every half-period.
  - When blink_phase=1, a digit inside blink_field keeps an deasserted; seg is still driven.
  - Left pair = idx3..2, right pair = idx1..0.
- dp:
  - Lit only on idx2, acting as the separator.
  - Lit when blink_phase=0; unlit when blink_phase=1.
  - Suppressed (unlit) while idx2 is blanked by blink.
- Mid-frame input change: it has no effect until the next frame boundary.
- Mid-frame view_sel change: it also takes effect only at the next frame boundary.
- Reset mid-scan: all outputs return to the reset state asynchronously. Scanning resumes from idx0 with a blank cycle first.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
  - Defined: when the snapshot tens digit at idx3 equals 0, idx3's anode stays deasserted for its whole slot. The prescaler timing is unchanged.
  - Undefined: leading zeros are displayed.

Decomposition:
- Package clock_disp_pkg:
  - SEG_0..SEG_9, SEG_DASH, SEG_OFF constants.
  - View enum VIEW_HHMM / VIEW_MMSS.
  - Blink-field enum.
- Sub-module bcd_to_seg: a purely combinational 4-bit-to-7-segment decoder using the package constants, instantiated once on the mux output.

Test Plan (CLK_HZ=1000, REFRESH_HZ=250 → 4 cycles/digit; BLINK_HZ=50 → 10-cycle half-period):
- Reset release, inputs 12:34:56, view 0, no blink → after the first frame boundary, an cycles E,D,B,7 with a blank F cycle between digits. seg shows 4,3,2,1 and dp is low only on idx2 during phase 0.
- view_sel=1 mid-frame → the current frame still shows 12.34; the next frame shows 34.56.
- blink_field=01 → during blink_phase=1, an[3] and an[2] stay high for at least 10 cycles while idx1/idx0 still scan. dp is high throughout that phase.
- min_1s forced to 4'hB → idx0 shows seg=7'b0111111.
- Inputs 05:07 with LEADING_ZERO_BLANK_EN defined → an[3] is never low. Without the macro, idx3 shows SEG_0.
- Assert disp_reset during the idx2 slot → the same cycle gives an=F, seg=7F, dp=1. After release, the first lit anode is an[0], after a blank cycle.

Source files
------------

// File: rtl/clock_disp_pkg.sv
// Shared types and segment patterns for the 4-digit clock display scanner.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package clock_disp_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef enum logic {
        VIEW_HHMM = 1'b0,
        VIEW_MMSS = 1'b1
    } view_e;

    typedef enum logic [1:0] {
        BLINK_NONE  = 2'b00,
        BLINK_LEFT  = 2'b01,
        BLINK_RIGHT = 2'b10,
        BLINK_ALL   = 2'b11
    } blink_e;

    typedef struct packed {
        logic [3:0] hr_10s;
        logic [3:0] hr_1s;
        logic [3:0] min_10s;
        logic [3:0] min_1s;
        logic [3:0] sec_10s;
        logic [3:0] sec_1s;
        view_e      view;
    } frame_t;

endpackage

// File: rtl/clock_display_scan_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Non-decimal codes show a dash so corrupted inputs are visible.
module bcd_to_seg
    import clock_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/clock_display_scan.sv
// Time-multiplexed 4-digit 7-segment driver with frame snapshot and blink.
// Optional: define LEADING_ZERO_BLANK_EN to blank a zero hours/minutes tens digit.
module clock_display_scan
    import clock_disp_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int BLINK_HZ   = 2
) (
    input  logic       clk_100mhz,
    input  logic       disp_reset,
    input  logic [3:0] hr_10s,
    input  logic [3:0] hr_1s,
    input  logic [3:0] min_10s,
    input  logic [3:0] min_1s,
    input  logic [3:0] sec_10s,
    input  logic [3:0] sec_1s,
    input  logic       view_sel,
    input  logic [1:0] blink_field,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CYC_RAW  = CLK_HZ / REFRESH_HZ;
    localparam int CYC      = (CYC_RAW < 2) ? 2 : CYC_RAW;
    localparam int HALF_RAW = CLK_HZ / (2 * BLINK_HZ);
    localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int PW       = $clog2(CYC + 1);
    localparam int BW       = $clog2(HALF + 1);
    localparam logic [PW-1:0] PS_LAST = PW'(CYC - 1);
    localparam logic [BW-1:0] BC_LAST = BW'(HALF - 1);

    frame_t          frame_in;
    frame_t          sync1_q, sync1_d;
    frame_t          sync2_q, sync2_d;
    frame_t          snap_q, snap_d;
    blink_e          blink1_q, blink1_d;
    blink_e          blink2_q, blink2_d;
    logic [PW-1:0]   ps_q, ps_d;
    logic [1:0]      idx_q, idx_d;
    logic [BW-1:0]   bc_q, bc_d;
    logic            phase_q, phase_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            scan_tick;
    logic            blink_tick;
    logic            mmss;
    logic            in_field;
    logic            hide;
    logic [3:0]      digit;
    logic [6:0]      dec_seg;

    assign frame_in = '{
        hr_10s:  hr_10s,
        hr_1s:   hr_1s,
        min_10s: min_10s,
        min_1s:  min_1s,
        sec_10s: sec_10s,
        sec_1s:  sec_1s,
        view:    view_e'(view_sel)
    };

    always_comb begin
        sync1_d  = frame_in;
        sync2_d  = sync1_q;
        blink1_d = blink_e'(blink_field);
        blink2_d = blink1_q;
    end

    // Scan timing; snapshot only at the frame boundary so a frame never tears.
    always_comb begin
        scan_tick  = (ps_q == PS_LAST);
        ps_d       = scan_tick ? '0 : ps_q + PW'(1);
        idx_d      = scan_tick ? idx_q + 2'd1 : idx_q;
        snap_d     = (scan_tick && idx_q == 2'd3) ? sync2_q : snap_q;
        blink_tick = (bc_q == BC_LAST);
        bc_d       = blink_tick ? '0 : bc_q + BW'(1);
        phase_d    = phase_q ^ blink_tick;
    end

    always_comb begin
        mmss  = (snap_q.view == VIEW_MMSS);
        digit = 4'd0;
        unique case (idx_q)
            2'd3: digit = mmss ? snap_q.min_10s : snap_q.hr_10s;
            2'd2: digit = mmss ? snap_q.min_1s  : snap_q.hr_1s;
            2'd1: digit = mmss ? snap_q.sec_10s : snap_q.min_10s;
            2'd0: digit = mmss ? snap_q.sec_1s  : snap_q.min_1s;
        endcase
    end

    bcd_to_seg u_dec (
        .bcd (digit),
        .seg (dec_seg)
    );

    always_comb begin
        in_field = 1'b0;
        unique case (blink2_q)
            BLINK_NONE:  in_field = 1'b0;
            BLINK_LEFT:  in_field = idx_q[1];
            BLINK_RIGHT: in_field = ~idx_q[1];
            BLINK_ALL:   in_field = 1'b1;
        endcase
        hide = phase_q & in_field;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_q == 2'd3 && digit == 4'd0) begin
            hide = 1'b1;
        end
`endif
    end

    // The cycle after scan_tick is blank to stop ghosting between digits.
    always_comb begin
        an_d  = 4'hF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (!scan_tick) begin
            an_d  = hide ? 4'hF : ~(4'b0001 << idx_q);
            seg_d = dec_seg;
            dp_d  = ~(idx_q == 2'd2 && !phase_q && !hide);
        end
    end

    always_ff @(posedge clk_100mhz or posedge disp_reset) begin
        if (disp_reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            snap_q   <= '0;
            blink1_q <= BLINK_NONE;
            blink2_q <= BLINK_NONE;
            ps_q     <= '0;
            idx_q    <= 2'd0;
            bc_q     <= '0;
            phase_q  <= 1'b0;
            an_q     <= 4'hF;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            snap_q   <= snap_d;
            blink1_q <= blink1_d;
            blink2_q <= blink2_d;
            ps_q     <= ps_d;
            idx_q    <= idx_d;
            bc_q     <= bc_d;
            phase_q  <= phase_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Self-checking bench for clock_display_scan against a cycle-count reference model.
// Honours LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_clock_display_scan;

    localparam int N     = 4;
    localparam int H     = 10;
    localparam int FRAME = 4 * N;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dig [6];
    logic       view_sel = 1'b0;
    logic [1:0] blink_field = 2'b00;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks   = 0;
    int failures = 0;

    // Reference model state: t = edges since reset release.
    int         t;
    logic [3:0] s1 [6];
    logic [3:0] s2 [6];
    logic [3:0] snap [6];
    logic       s1v, s2v, snapv;
    logic [1:0] b1, b2;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;

    logic [6:0] seg_tab [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    always #5 clk = ~clk;

    clock_display_scan #(
        .CLK_HZ     (1000),
        .REFRESH_HZ (250),
        .BLINK_HZ   (50)
    ) dut (
        .clk_100mhz  (clk),
        .disp_reset  (rst),
        .hr_10s      (dig[0]),
        .hr_1s       (dig[1]),
        .min_10s     (dig[2]),
        .min_1s      (dig[3]),
        .sec_10s     (dig[4]),
        .sec_1s      (dig[5]),
        .view_sel    (view_sel),
        .blink_field (blink_field),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < 6; i++) begin
            s1[i] = 4'd0;
            s2[i] = 4'd0;
            snap[i] = 4'd0;
        end
        s1v = 1'b0; s2v = 1'b0; snapv = 1'b0;
        b1 = 2'b00; b2 = 2'b00;
    endtask

    // Expected registered outputs produced from the pre-edge state t.
    task automatic model_expect();
        int idx, phase, base;
        logic [3:0] d;
        logic infield, hidden;
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
        if (t % N != N - 1) begin
            idx   = (t / N) % 4;
            phase = (t / H) % 2;
            base  = snapv ? 5 : 3;
            d     = snap[base - idx];
            case (b2)
                2'b01: infield = (idx >= 2);
                2'b10: infield = (idx < 2);
                2'b11: infield = 1'b1;
                default: infield = 1'b0;
            endcase
            hidden = (phase == 1) && infield;
`ifdef LEADING_ZERO_BLANK_EN
            if (idx == 3 && d == 4'd0) hidden = 1'b1;
`endif
            exp_an  = hidden ? 4'hF : (4'hF ^ (4'd1 << idx));
            exp_seg = (d > 9) ? 7'b0111111 : seg_tab[d];
            exp_dp  = (idx == 2 && phase == 0) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_expect();
        if (t % FRAME == FRAME - 1) begin
            for (int i = 0; i < 6; i++) snap[i] = s2[i];
            snapv = s2v;
        end
        for (int i = 0; i < 6; i++) begin
            s2[i] = s1[i];
            s1[i] = dig[i];
        end
        s2v = s1v; s1v = view_sel;
        b2 = b1; b1 = blink_field;
        t++;
        #1;
        chk("an", 32'(an), 32'(exp_an));
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("dp", 32'(dp), 32'(exp_dp));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_time(input int h10, input int h1, input int m10,
                            input int m1, input int s10, input int sx);
        dig[0] = 4'(h10); dig[1] = 4'(h1); dig[2] = 4'(m10);
        dig[3] = 4'(m1);  dig[4] = 4'(s10); dig[5] = 4'(sx);
    endtask

    initial begin
        int run_len, best, an3_low;
        set_time(1, 2, 3, 4, 5, 6);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_dp", 32'(dp), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        run(2 * FRAME + 4);

        // view change mid-frame
        while (t % FRAME != 6) step();
        view_sel = 1'b1;
        run(2 * FRAME + 8);

        // blink left pair
        view_sel = 1'b0;
        blink_field = 2'b01;
        run_len = 0; best = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (an[3:2] == 2'b11) run_len++;
            else run_len = 0;
            if (run_len > best) best = run_len;
        end
        chk("blink_left_window", 32'(best >= 10), 32'd1);

        // out-of-range digit
        blink_field = 2'b00;
        dig[3] = 4'hB;
        run(2 * FRAME + 4);

        // leading zero
        set_time(0, 5, 0, 7, 0, 0);
        run(FRAME + 4);
        an3_low = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (an[3] == 1'b0) an3_low++;
        end
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_an3_never_low", 32'(an3_low), 32'd0);
`else
        chk("lz_an3_shown", 32'(an3_low > 0), 32'd1);
`endif

        // randomized inputs
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) dig[$urandom_range(0, 5)] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) view_sel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) blink_field = 2'($urandom_range(0, 3));
            step();
        end

        // asynchronous reset during the idx2 slot
        while (!((t / N) % 4 == 2 && t % N == 1)) step();
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_an", 32'(an), 32'hF);
        chk("midreset_seg", 32'(seg), 32'h7F);
        chk("midreset_dp", 32'(dp), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("release_blank", 32'(an), 32'hF);
        step();
        chk("first_lit_an0", 32'(an), 32'hE);
        run(3 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
